ex_muldiv_alu: RTL and testbench

- Parametrised execute stage for the MIPS-style 5-stage core; it is the successor of the single-op logic EX stage.
- Implements logic, shift, move, arithmetic, multiply and iterative divide, and owns the HI/LO register pair.
- Combinational result path to EX/MEM; sequential divider FSM drives a stall request to the pipeline controller.

---
 rtl/ex_muldiv_alu_pkg.sv | 49 ++++
 rtl/ex_div_iter.sv | 101 ++++++++++
 rtl/ex_muldiv_alu.sv | 182 ++++++++++++++++++
 tb/tb_ex_muldiv_alu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_alu_pkg.sv
// Shared opcode header for the EX stage: result classes, operation codes
// and the divider state encoding.
package ex_muldiv_alu_pkg;

   // Result class (alu_sel)
   localparam logic [2:0] SEL_NOP   = 3'd0;
   localparam logic [2:0] SEL_LOGIC = 3'd1;
   localparam logic [2:0] SEL_SHIFT = 3'd2;
   localparam logic [2:0] SEL_MOVE  = 3'd3;
   localparam logic [2:0] SEL_ARITH = 3'd4;
   localparam logic [2:0] SEL_MUL   = 3'd5;

   // Logic
   localparam logic [7:0] OP_AND   = 8'b0010_0100;
   localparam logic [7:0] OP_OR    = 8'b0010_0101;
   localparam logic [7:0] OP_XOR   = 8'b0010_0110;
   localparam logic [7:0] OP_NOR   = 8'b0010_0111;
   // Shift
   localparam logic [7:0] OP_SLL   = 8'b0111_1100;
   localparam logic [7:0] OP_SRL   = 8'b0000_0010;
   localparam logic [7:0] OP_SRA   = 8'b0000_0011;
   // Move
   localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
   localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
   localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
   localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
   localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
   localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
   // Arithmetic
   localparam logic [7:0] OP_ADD   = 8'b0010_0000;
   localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
   localparam logic [7:0] OP_SUB   = 8'b0010_0010;
   localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
   localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
   localparam logic [7:0] OP_SLT   = 8'b0010_1010;
   localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
   // Multiply / divide
   localparam logic [7:0] OP_MULT  = 8'b0001_1000;
   localparam logic [7:0] OP_MULTU = 8'b0001_1001;
   localparam logic [7:0] OP_MUL   = 8'b1010_1001;
   localparam logic [7:0] OP_DIV   = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

   // Divider FSM encoding
   localparam logic [1:0] DIV_IDLE = 2'd0;
   localparam logic [1:0] DIV_BUSY = 2'd1;
   localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/ex_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// signs re-applied on the way out. Zero divisor short-circuits to DONE.
module ex_div_iter
   import ex_muldiv_alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              abort,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic [1:0]        state
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] quot;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] dvs;
   logic              neg_q;
   logic              neg_r;

   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [DATA_W:0]   partial;
   logic [DATA_W:0]   trial;

   assign a_mag = (signed_en && a[DATA_W-1]) ? -a : a;
   assign b_mag = (signed_en && b[DATA_W-1]) ? -b : b;

   // rem < dvs always holds, so partial fits in DATA_W+1 bits and the
   // top bit of trial is the borrow of the trial subtraction.
   assign partial = {rem, quot[DATA_W-1]};
   assign trial   = partial - {1'b0, dvs};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DIV_IDLE;
         cnt   <= '0;
         quot  <= '0;
         rem   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (abort) begin
         state <= DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  if (b == '0) begin
                     quot  <= '1;
                     rem   <= a;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= DIV_DONE;
                  end else begin
                     quot  <= a_mag;
                     rem   <= '0;
                     dvs   <= b_mag;
                     neg_q <= signed_en && (a[DATA_W-1] ^ b[DATA_W-1]);
                     neg_r <= signed_en && a[DATA_W-1];
                     cnt   <= '0;
                     state <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               if (!trial[DATA_W]) begin
                  rem  <= trial[DATA_W-1:0];
                  quot <= {quot[DATA_W-2:0], 1'b1};
               end else begin
                  rem  <= partial[DATA_W-1:0];
                  quot <= {quot[DATA_W-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W - 1)) state <= DIV_DONE;
            end
            DIV_DONE: begin
               if (!hold) state <= DIV_IDLE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   assign busy      = (state == DIV_BUSY);
   assign done      = (state == DIV_DONE);
   assign quotient  = neg_q ? -quot : quot;
   assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/ex_muldiv_alu.sv
// Execute stage: combinational logic/shift/move/arith/mul result path,
// HI/LO register pair, and an iterative divider that freezes the pipeline.
module ex_muldiv_alu
   import ex_muldiv_alu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int OP_W       = 8,
   parameter int SEL_W      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [OP_W-1:0]       alu_op,
   input  logic [SEL_W-1:0]      alu_sel,
   input  logic [DATA_W-1:0]     operand_1,
   input  logic [DATA_W-1:0]     operand_2,
   input  logic [REG_ADDR_W-1:0] reg_write_addr_i,
   input  logic                  reg_write_en_i,
   input  logic                  flush,
   input  logic                  stall_i,
   output logic [DATA_W-1:0]     reg_write_data_o,
   output logic [REG_ADDR_W-1:0] reg_write_addr_o,
   output logic                  reg_write_en_o,
   output logic                  ovf_o,
   output logic                  stall_req_o
);

   localparam int SH_W = $clog2(DATA_W);

   logic [7:0]          op;
   logic [2:0]          sel;
   logic [DATA_W-1:0]   hi;
   logic [DATA_W-1:0]   lo;
   logic [SH_W-1:0]     shamt;
   logic [DATA_W-1:0]   sum;
   logic [DATA_W-1:0]   diff;
   logic                add_ovf;
   logic                sub_ovf;
   logic [2*DATA_W-1:0] prod_s;
   logic [2*DATA_W-1:0] prod_u;

   logic                is_div;
   logic                div_busy;
   logic                div_done;
   logic [DATA_W-1:0]   div_q;
   logic [DATA_W-1:0]   div_r;
   logic [1:0]          div_state;
   logic                div_start;
   logic                div_commit;
   logic                hilo_ok;

   logic [DATA_W-1:0]   res;
   logic                wr;
   logic                ovf;

   assign op    = 8'(alu_op);
   assign sel   = 3'(alu_sel);
   assign shamt = operand_1[SH_W-1:0];

   assign sum     = operand_1 + operand_2;
   assign diff    = operand_1 - operand_2;
   assign add_ovf = (operand_1[DATA_W-1] == operand_2[DATA_W-1]) &&
                    (sum[DATA_W-1] != operand_1[DATA_W-1]);
   assign sub_ovf = (operand_1[DATA_W-1] != operand_2[DATA_W-1]) &&
                    (diff[DATA_W-1] != operand_1[DATA_W-1]);

   assign prod_s = {{DATA_W{operand_1[DATA_W-1]}}, operand_1} *
                   {{DATA_W{operand_2[DATA_W-1]}}, operand_2};
   assign prod_u = {{DATA_W{1'b0}}, operand_1} * {{DATA_W{1'b0}}, operand_2};

   assign is_div = (sel == SEL_MUL) && ((op == OP_DIV) || (op == OP_DIVU));

   ex_div_iter #(.DATA_W(DATA_W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (is_div),
      .signed_en (op == OP_DIV),
      .a         (operand_1),
      .b         (operand_2),
      .abort     (flush),
      .hold      (stall_i),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r),
      .state     (div_state)
   );

   // A divide launching from IDLE already freezes the pipe in that cycle.
   assign div_start   = is_div && (div_state == DIV_IDLE);
   assign stall_req_o = !rst && !flush && (div_start || div_busy);

   always_comb begin
      res = '0;
      wr  = 1'b0;
      ovf = 1'b0;
      case (sel)
         SEL_LOGIC: begin
            wr = 1'b1;
            case (op)
               OP_AND:  res = operand_1 & operand_2;
               OP_OR:   res = operand_1 | operand_2;
               OP_XOR:  res = operand_1 ^ operand_2;
               OP_NOR:  res = ~(operand_1 | operand_2);
               default: wr = 1'b0;
            endcase
         end
         SEL_SHIFT: begin
            wr = 1'b1;
            case (op)
               OP_SLL:  res = operand_2 << shamt;
               OP_SRL:  res = operand_2 >> shamt;
               OP_SRA:  res = $signed(operand_2) >>> shamt;
               default: wr = 1'b0;
            endcase
         end
         SEL_MOVE: begin
            case (op)
               OP_MFHI: begin res = hi; wr = 1'b1; end
               OP_MFLO: begin res = lo; wr = 1'b1; end
               OP_MOVZ: begin res = operand_1; wr = (operand_2 == '0); end
               OP_MOVN: begin res = operand_1; wr = (operand_2 != '0); end
               default: ;
            endcase
         end
         SEL_ARITH: begin
            case (op)
               OP_ADD, OP_ADDI: begin res = sum;  ovf = add_ovf; wr = !add_ovf; end
               OP_SUB:          begin res = diff; ovf = sub_ovf; wr = !sub_ovf; end
               OP_ADDU:         begin res = sum;  wr = 1'b1; end
               OP_SUBU:         begin res = diff; wr = 1'b1; end
               OP_SLT: begin
                  res = {{(DATA_W-1){1'b0}}, $signed(operand_1) < $signed(operand_2)};
                  wr  = 1'b1;
               end
               OP_SLTU: begin
                  res = {{(DATA_W-1){1'b0}}, operand_1 < operand_2};
                  wr  = 1'b1;
               end
               default: ;
            endcase
         end
         SEL_MUL: begin
            if (op == OP_MUL) begin
               res = prod_s[DATA_W-1:0];
               wr  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign reg_write_data_o = rst ? '0 : res;
   assign reg_write_addr_o = rst ? '0 : reg_write_addr_i;
   assign reg_write_en_o   = !rst && !flush && wr && reg_write_en_i;
   assign ovf_o            = !rst && !flush && ovf;

   assign hilo_ok    = !stall_i && !flush && !stall_req_o;
   assign div_commit = div_done && hilo_ok;

   // Divider result wins over any same-cycle MULT/MTHI/MTLO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (div_commit) begin
         hi <= div_r;
         lo <= div_q;
      end else if (hilo_ok) begin
         if (sel == SEL_MUL && op == OP_MULT) begin
            {hi, lo} <= prod_s;
         end else if (sel == SEL_MUL && op == OP_MULTU) begin
            {hi, lo} <= prod_u;
         end else if (sel == SEL_MOVE && op == OP_MTHI) begin
            hi <= operand_1;
         end else if (sel == SEL_MOVE && op == OP_MTLO) begin
            lo <= operand_1;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_alu.sv
// Directed-vector bench for ex_muldiv_alu with hand-computed expectations.
module tb_ex_muldiv_alu;
   import ex_muldiv_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  alu_op;
   logic [2:0]  alu_sel;
   logic [31:0] operand_1;
   logic [31:0] operand_2;
   logic [4:0]  reg_write_addr_i;
   logic        reg_write_en_i;
   logic        flush;
   logic        stall_i;
   logic [31:0] reg_write_data_o;
   logic [4:0]  reg_write_addr_o;
   logic        reg_write_en_o;
   logic        ovf_o;
   logic        stall_req_o;

   int total = 0;
   int bad   = 0;
   int n;

   ex_muldiv_alu dut (
      .clk              (clk),
      .rst              (rst),
      .alu_op           (alu_op),
      .alu_sel          (alu_sel),
      .operand_1        (operand_1),
      .operand_2        (operand_2),
      .reg_write_addr_i (reg_write_addr_i),
      .reg_write_en_i   (reg_write_en_i),
      .flush            (flush),
      .stall_i          (stall_i),
      .reg_write_data_o (reg_write_data_o),
      .reg_write_addr_o (reg_write_addr_o),
      .reg_write_en_o   (reg_write_en_o),
      .ovf_o            (ovf_o),
      .stall_req_o      (stall_req_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [2:0] s, input logic [7:0] o,
                        input logic [31:0] a, input logic [31:0] b);
      alu_sel   = s;
      alu_op    = o;
      operand_1 = a;
      operand_2 = b;
      #1;
   endtask

   task automatic wait_div(output int cycles);
      cycles = 0;
      while (stall_req_o && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      drive(SEL_MOVE, OP_MFHI, 32'h0, 32'h0);
      chk({tag, "_hi"}, reg_write_data_o, exp_hi);
      drive(SEL_MOVE, OP_MFLO, 32'h0, 32'h0);
      chk({tag, "_lo"}, reg_write_data_o, exp_lo);
   endtask

   initial begin
      // reset overrides all inputs
      rst = 1'b1; flush = 1'b0; stall_i = 1'b0;
      reg_write_en_i = 1'b1; reg_write_addr_i = 5'd9;
      drive(SEL_LOGIC, OP_OR, 32'hFFFF_FFFF, 32'h1);
      chk("rst_data", reg_write_data_o, 32'h0);
      chk("rst_en", {31'b0, reg_write_en_o}, 32'h0);
      chk("rst_addr", {27'b0, reg_write_addr_o}, 32'h0);
      drive(SEL_MUL, OP_DIV, 32'd8, 32'd3);
      chk("rst_stall", {31'b0, stall_req_o}, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      drive(SEL_NOP, 8'h00, 32'h0, 32'h0);
      chk_hilo("rst_hilo", 32'h0, 32'h0);

      // logic / shift
      drive(SEL_LOGIC, OP_OR, 32'h0000_FF00, 32'h00F0_000F);
      chk("or_data", reg_write_data_o, 32'h00F0_FF0F);
      chk("or_en", {31'b0, reg_write_en_o}, 32'h1);
      chk("or_addr", {27'b0, reg_write_addr_o}, 32'd9);
      tick();
      drive(SEL_SHIFT, OP_SRA, 32'd4, 32'h8000_0000);
      chk("sra", reg_write_data_o, 32'hF800_0000);
      drive(SEL_SHIFT, OP_SRL, 32'd36, 32'h8000_0000);
      chk("srl_amt_mod", reg_write_data_o, 32'h0800_0000);
      tick();
      drive(SEL_LOGIC, OP_NOR, 32'hF0F0_0000, 32'h0000_0F0F);
      chk("nor", reg_write_data_o, 32'h0F0F_F0F0);
      drive(SEL_LOGIC, 8'hFF, 32'h1234, 32'h5678);
      chk("unk_data", reg_write_data_o, 32'h0);
      tick();
      chk("unk_en", {31'b0, reg_write_en_o}, 32'h0);
      drive(SEL_NOP, OP_OR, 32'h1234, 32'h5678);
      chk("nop_data", reg_write_data_o, 32'h0);

      // arithmetic and overflow
      tick();
      drive(SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'h1);
      chk("add_ovf", {31'b0, ovf_o}, 32'h1);
      chk("add_ovf_en", {31'b0, reg_write_en_o}, 32'h0);
      chk("add_ovf_data", reg_write_data_o, 32'h8000_0000);
      drive(SEL_ARITH, OP_ADDU, 32'h7FFF_FFFF, 32'h1);
      chk("addu_data", reg_write_data_o, 32'h8000_0000);
      tick();
      chk("addu_en", {31'b0, reg_write_en_o}, 32'h1);
      chk("addu_ovf", {31'b0, ovf_o}, 32'h0);
      drive(SEL_ARITH, OP_SUB, 32'h8000_0000, 32'h1);
      chk("sub_ovf", {31'b0, ovf_o}, 32'h1);
      tick();
      drive(SEL_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'h1);
      chk("slt", reg_write_data_o, 32'h1);
      drive(SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'h1);
      chk("sltu", reg_write_data_o, 32'h0);
      tick();
      drive(SEL_LOGIC, OP_OR, 32'h1, 32'h2);
      flush = 1'b1; #1;
      chk("flush_en", {31'b0, reg_write_en_o}, 32'h0);
      flush = 1'b0;

      // moves
      tick();
      drive(SEL_MOVE, OP_MOVZ, 32'hAAAA_5555, 32'd5);
      chk("movz_en", {31'b0, reg_write_en_o}, 32'h0);
      drive(SEL_MOVE, OP_MOVN, 32'hAAAA_5555, 32'd5);
      chk("movn_data", reg_write_data_o, 32'hAAAA_5555);
      tick();
      chk("movn_en", {31'b0, reg_write_en_o}, 32'h1);
      drive(SEL_MOVE, OP_MTHI, 32'h0000_1234, 32'h0);
      chk("mthi_en", {31'b0, reg_write_en_o}, 32'h0);
      tick();
      drive(SEL_MOVE, OP_MTLO, 32'h0000_5678, 32'h0);
      tick();
      chk_hilo("mt", 32'h0000_1234, 32'h0000_5678);

      // multiply
      tick();
      drive(SEL_MUL, OP_MULT, 32'hFFFF_FFFD, 32'd5);
      chk("mult_en", {31'b0, reg_write_en_o}, 32'h0);
      tick();
      chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      tick();
      drive(SEL_MUL, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      tick();
      chk_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
      tick();
      drive(SEL_MUL, OP_MUL, 32'd7, 32'd6);
      chk("mul_data", reg_write_data_o, 32'd42);
      chk("mul_en", {31'b0, reg_write_en_o}, 32'h1);
      tick();
      chk_hilo("mul_keep", 32'h0000_0001, 32'hFFFF_FFFE);

      // signed divide
      tick();
      drive(SEL_MUL, OP_DIV, 32'hFFFF_FFF8, 32'd3);
      chk("div_en", {31'b0, reg_write_en_o}, 32'h0);
      wait_div(n);
      chk("div_stall_cycles", n, 32'd33);
      tick();
      chk_hilo("div", 32'hFFFF_FFFE, 32'hFFFF_FFFE);

      // unsigned divide
      tick();
      drive(SEL_MUL, OP_DIVU, 32'd100, 32'd7);
      wait_div(n);
      chk("divu_stall_cycles", n, 32'd33);
      tick();
      chk_hilo("divu", 32'd2, 32'd14);

      // divide by zero
      tick();
      drive(SEL_MUL, OP_DIVU, 32'h0000_0055, 32'h0);
      wait_div(n);
      chk("div0_stall_cycles", n, 32'd1);
      tick();
      chk_hilo("div0", 32'h0000_0055, 32'hFFFF_FFFF);

      // flush in the tenth busy cycle
      tick();
      drive(SEL_MUL, OP_DIVU, 32'd100, 32'd7);
      repeat (10) tick();
      chk("flush_pre_stall", {31'b0, stall_req_o}, 32'h1);
      flush = 1'b1; #1;
      chk("flush_stall", {31'b0, stall_req_o}, 32'h0);
      tick();
      flush = 1'b0;
      drive(SEL_NOP, 8'h00, 32'h0, 32'h0);
      chk("flush_idle", {31'b0, stall_req_o}, 32'h0);
      tick();
      chk_hilo("flush", 32'h0000_0055, 32'hFFFF_FFFF);

      // downstream stall holds DONE for three cycles
      tick();
      drive(SEL_MUL, OP_DIV, 32'hFFFF_FF9C, 32'd7);
      wait_div(n);
      chk("hold_stall_cycles", n, 32'd33);
      stall_i = 1'b1;
      drive(SEL_MOVE, OP_MFHI, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("hold_no_req", {31'b0, stall_req_o}, 32'h0);
         chk("hold_hi", reg_write_data_o, 32'h0000_0055);
         tick();
      end
      stall_i = 1'b0;
      tick();
      chk_hilo("hold", 32'hFFFF_FFFE, 32'hFFFF_FFF2);

      // reset in the middle of a divide
      tick();
      drive(SEL_MUL, OP_DIV, 32'd8, 32'd3);
      repeat (5) tick();
      rst = 1'b1; #1;
      chk("midrst_stall", {31'b0, stall_req_o}, 32'h0);
      drive(SEL_NOP, 8'h00, 32'h0, 32'h0);
      tick();
      rst = 1'b0; #1;
      chk("midrst_idle", {31'b0, stall_req_o}, 32'h0);
      chk_hilo("midrst", 32'h0, 32'h0);
      tick();
      drive(SEL_MUL, OP_DIVU, 32'd9, 32'd3);
      wait_div(n);
      chk("post_rst_stall_cycles", n, 32'd33);
      tick();
      chk_hilo("post_rst", 32'h0, 32'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
